// File: rtl/ysyx_25040109_ifu.sv
// Instruction fetch unit: a 5-state FSM that fetches one instruction, hands it to decode,
// then waits for the resolved next PC. Optional perf counters under YSYX_25040109_IFU_PERF_EN.
module ysyx_25040109_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        commit_valid,
  input  logic [31:0] commit_next_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`ifdef YSYX_25040109_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_RESP = 3'd1;
  localparam logic [2:0] S_OUT  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic [31:0] fault_pc_reg;
  logic        fetch_fault_reg;

  logic resp_ok, resp_bad, commit_ok, commit_bad;

  assign resp_ok    = (state_reg == S_RESP) && imem_resp_valid && !imem_resp_err;
  assign resp_bad   = (state_reg == S_RESP) && imem_resp_valid && imem_resp_err;
  assign commit_ok  = (state_reg == S_EXEC) && commit_valid && (commit_next_pc[1:0] == 2'b00);
  assign commit_bad = (state_reg == S_EXEC) && commit_valid && (commit_next_pc[1:0] != 2'b00);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_REQ:   if (imem_req_ready) state_next = S_RESP;
      S_RESP:  begin
        if (resp_bad)     state_next = S_HALT;
        else if (resp_ok) state_next = S_OUT;
      end
      S_OUT:   if (inst_ready) state_next = S_EXEC;
      S_EXEC:  begin
        if (commit_bad)     state_next = S_HALT;
        else if (commit_ok) state_next = S_REQ;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_REQ;
      pc_reg          <= RESET_PC;
      inst_reg        <= 32'd0;
      inst_pc_reg     <= 32'd0;
      fault_pc_reg    <= 32'd0;
      fetch_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (resp_ok) begin
        inst_reg    <= imem_resp_data;
        inst_pc_reg <= pc_reg;
      end
      // A faulting response never touches inst; the fault takes priority.
      if (resp_bad) begin
        fetch_fault_reg <= 1'b1;
        fault_pc_reg    <= pc_reg;
      end
      if (commit_bad) begin
        fetch_fault_reg <= 1'b1;
        fault_pc_reg    <= commit_next_pc;
      end
      if (commit_ok) pc_reg <= commit_next_pc;
    end
  end

  // Handshake valids are pure state decodes, with no input-to-output path.
  assign imem_req_valid = (state_reg == S_REQ);
  assign imem_req_addr  = pc_reg;
  assign inst_valid     = (state_reg == S_OUT);
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
  assign fetch_fault    = fetch_fault_reg;
  assign fault_pc       = fault_pc_reg;

`ifdef YSYX_25040109_IFU_PERF_EN
  logic [31:0] perf_fetch_reg, perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_reg <= 32'd0;
      perf_stall_reg <= 32'd0;
    end else begin
      if (resp_ok) perf_fetch_reg <= perf_fetch_reg + 32'd1;
      if (((state_reg == S_REQ) && !imem_req_ready) ||
          ((state_reg == S_RESP) && !imem_resp_valid))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_reg;
  assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Scoreboard bench for ysyx_25040109_ifu: directed fetch sequences push expected requests
// and instructions into queues; a negedge monitor compares whatever the DUT presents.
module tb_ysyx_25040109_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
`ifdef YSYX_25040109_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_25040109_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .commit_valid   (commit_valid),
    .commit_next_pc (commit_next_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
`ifdef YSYX_25040109_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: expected values stay at the queue head until the handshake completes,
  // so every stalled cycle is also checked for stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid) begin
        if (req_q.size() == 0) begin
          if (imem_req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_dup: got request addr %h, expected none", imem_req_addr);
          end
        end else begin
          check("req_addr", imem_req_addr, req_q[0]);
          if (imem_req_ready) begin
            $display("req  addr=%h", imem_req_addr);
            void'(req_q.pop_front());
          end
        end
      end
      if (inst_valid) begin
        if (inst_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL inst_extra: got inst %h pc %h, expected none", inst, inst_pc);
        end else begin
          check("inst_word", inst, inst_q[0][63:32]);
          check("inst_pc", inst_pc, inst_q[0][31:0]);
          if (inst_ready) begin
            $display("inst pc=%h word=%h", inst_pc, inst);
            void'(inst_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    commit_valid    = 1'b0;
    commit_next_pc  = 32'd0;
    step();
    step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
`ifdef YSYX_25040109_IFU_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    req_q.delete();
    inst_q.delete();
    rst = 1'b0;
  endtask

  // One instruction from S_REQ through commit; each phase takes exactly its cycle count.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       input logic [31:0] nxt, input int req_stall, input int resp_lat,
                       input int out_stall, input bit commit_in_out);
    req_q.push_back(addr);
    if (!err) inst_q.push_back({data, addr});
    check("req_now", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b0;
    repeat (req_stall) step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("resp_idle", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    imem_resp_err = 1'b1;
    repeat (resp_lat) step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    if (err) begin
      check("err_fault", {31'd0, fetch_fault}, 32'd1);
      check("err_fault_pc", fault_pc, addr);
      return;
    end
    check("inst_lat", {31'd0, inst_valid}, 32'd1);
    if (commit_in_out) begin
      commit_valid   = 1'b1;
      commit_next_pc = 32'h8000_0100;
      step();
      commit_valid = 1'b0;
    end
    repeat (out_stall) step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("exec_idle", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    commit_valid   = 1'b1;
    commit_next_pc = nxt;
    step();
    commit_valid = 1'b0;
  endtask

  initial begin
    // Straight-line fetch, a jump with a stray commit in S_OUT, then a fetch fault.
    do_reset();
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 32'h8000_0004, 0, 0, 0, 1'b0);
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 32'h8000_1000, 0, 0, 0, 1'b1);
    fetch(32'h8000_1000, 32'h0020_8113, 1'b0, 32'h8000_0008, 0, 0, 0, 1'b0);
    fetch(32'h8000_0008, 32'h0000_0000, 1'b1, 32'h0000_0000, 0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_quiet", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    end
    check("halt_sticky", {31'd0, fetch_fault}, 32'd1);

    // Backpressure on both ports, then slow response and a misaligned commit.
    do_reset();
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 32'h8000_0004, 3, 0, 5, 1'b0);
`ifdef YSYX_25040109_IFU_PERF_EN
    check("perf_stall", perf_stall_cnt, 32'd3);
    check("perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    fetch(32'h8000_0004, 32'h0050_0513, 1'b0, 32'h8000_0006, 0, 2, 0, 1'b0);
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'h8000_0006);
    repeat (3) step();
    check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);

    // Async reset while in S_RESP; a late response must be dropped.
    do_reset();
    req_q.push_back(RESET_PC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("async_req_addr", imem_req_addr, RESET_PC);
    step();
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_0BAD;
    step();
    imem_resp_valid = 1'b0;
    req_q.delete();
    inst_q.delete();
    fetch(RESET_PC, 32'h0000_0413, 1'b0, 32'hFFFF_FFFC, 0, 1, 1, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 32'h8000_0000, 1, 0, 0, 1'b0);
    check("top_no_fault", {31'd0, fetch_fault}, 32'd0);
    check("wrap_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    check("req_q_empty", req_q.size(), 32'd0);
    check("inst_q_empty", inst_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
